// File: rtl/port_read_scheduler.sv
// port_read_scheduler: round-robin reader for four switch output ports that
// merges one whole packet at a time into a framed, backpressured byte stream.
module port_read_scheduler #(
  parameter int CNT_W = 16
) (
  input  logic             slow_clk,
  input  logic             reset_b,
  input  logic             ready_0,
  input  logic             ready_1,
  input  logic             ready_2,
  input  logic             ready_3,
  output logic             read_0,
  output logic             read_1,
  output logic             read_2,
  output logic             read_3,
  input  logic [7:0]       port0,
  input  logic [7:0]       port1,
  input  logic [7:0]       port2,
  input  logic [7:0]       port3,
  output logic             out_valid,
  output logic [7:0]       out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic [1:0]       out_port,
  input  logic             out_stall,
  output logic             parity_err,
  output logic [CNT_W-1:0] pkt_cnt
);
  typedef enum logic [1:0] {IDLE, XFER, DONE} state_e;

  state_e           state_q, state_d;
  logic [1:0]       rr_q, rr_d, grant_q, pick;
  logic [3:0]       ready_vec;
  logic             any_ready;
  logic [8:0]       issued_q, rcv_q, tot_w;
  logic [7:0]       len_q, par_q, in_byte;
  logic             len_known_q, inflight_q;
  logic [7:0]       fdata_q [2];
  logic [1:0]       fsop_q, feop_q;
  logic             wr_ptr_q, rd_ptr_q;
  logic [1:0]       count_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rd_en, pop, push, push_sop, push_eop, head_eop;
  logic [2:0]       pending;

  assign ready_vec = {ready_3, ready_2, ready_1, ready_0};

  always_comb begin
    pick      = rr_q;
    any_ready = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (!any_ready && ready_vec[rr_q + 2'(i)]) begin
        pick      = rr_q + 2'(i);
        any_ready = 1'b1;
      end
    end
  end

  always_comb begin
    case (grant_q)
      2'd0:    in_byte = port0;
      2'd1:    in_byte = port1;
      2'd2:    in_byte = port2;
      default: in_byte = port3;
    endcase
  end

  // Length byte arriving this cycle already widens the read window.
  always_comb begin
    if (len_known_q)                        tot_w = {1'b0, len_q} + 9'd3;
    else if (inflight_q && rcv_q == 9'd1)   tot_w = {1'b0, in_byte} + 9'd3;
    else                                    tot_w = 9'd3;
  end

  assign push      = inflight_q;
  assign push_sop  = (rcv_q == 9'd0);
  assign push_eop  = (rcv_q == tot_w - 9'd1);
  assign out_valid = (count_q != 2'd0);
  assign pop       = out_valid && !out_stall;
  assign head_eop  = feop_q[rd_ptr_q];
  assign out_data  = fdata_q[rd_ptr_q];
  assign out_sop   = out_valid && fsop_q[rd_ptr_q];
  assign out_eop   = out_valid && head_eop;
  assign out_port  = grant_q;
  assign pkt_cnt   = cnt_q;
  assign parity_err = pop && head_eop && (par_q != fdata_q[rd_ptr_q]);

  // Occupancy is taken after this cycle's pop so an unstalled stream reads back-to-back.
  assign pending = {1'b0, count_q} - {2'b0, pop} + {2'b0, inflight_q};

  always_ff @(posedge slow_clk or negedge reset_b) begin
    if (!reset_b) begin
      state_q <= IDLE;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (any_ready) state_d = XFER;
      XFER: if (pop && head_eop) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        rr_d    = grant_q + 2'd1;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rd_en  = (state_q == XFER) && (issued_q < tot_w) && (pending < 3'd2);
    read_0 = rd_en && (grant_q == 2'd0);
    read_1 = rd_en && (grant_q == 2'd1);
    read_2 = rd_en && (grant_q == 2'd2);
    read_3 = rd_en && (grant_q == 2'd3);
  end

  always_ff @(posedge slow_clk or negedge reset_b) begin
    if (!reset_b) begin
      grant_q     <= '0;
      issued_q    <= '0;
      rcv_q       <= '0;
      len_q       <= '0;
      len_known_q <= 1'b0;
      par_q       <= '0;
      inflight_q  <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) fdata_q[i] <= '0;
      fsop_q      <= '0;
      feop_q      <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      count_q     <= '0;
    end else begin
      inflight_q <= rd_en;
      if (state_q == IDLE && any_ready) begin
        grant_q     <= pick;
        issued_q    <= '0;
        rcv_q       <= '0;
        len_known_q <= 1'b0;
        par_q       <= '0;
      end
      if (rd_en) issued_q <= issued_q + 9'd1;
      if (push) begin
        rcv_q <= rcv_q + 9'd1;
        if (rcv_q == 9'd1) begin
          len_q       <= in_byte;
          len_known_q <= 1'b1;
        end
        if (!push_eop) par_q <= par_q ^ in_byte;
        fdata_q[wr_ptr_q] <= in_byte;
        fsop_q[wr_ptr_q]  <= push_sop;
        feop_q[wr_ptr_q]  <= push_eop;
        wr_ptr_q          <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_q + {1'b0, push} - {1'b0, pop};
    end
  end
endmodule

// File: tb/tb_port_read_scheduler.sv
// Bench for port_read_scheduler: packet-level port models and a scoreboard
// that predicts grants, stream contents, parity pulses and packet count.
module tb_port_read_scheduler;
  logic        slow_clk = 1'b0;
  logic        reset_b  = 1'b0;
  logic        ready_0 = 1'b0, ready_1 = 1'b0, ready_2 = 1'b0, ready_3 = 1'b0;
  logic        read_0, read_1, read_2, read_3;
  logic [7:0]  port0 = '0, port1 = '0, port2 = '0, port3 = '0;
  logic        out_valid, out_sop, out_eop, parity_err;
  logic [7:0]  out_data;
  logic [1:0]  out_port;
  logic        out_stall = 1'b0;
  logic [15:0] pkt_cnt;

  port_read_scheduler #(.CNT_W(16)) dut (
    .slow_clk(slow_clk), .reset_b(reset_b),
    .ready_0(ready_0), .ready_1(ready_1), .ready_2(ready_2), .ready_3(ready_3),
    .read_0(read_0), .read_1(read_1), .read_2(read_2), .read_3(read_3),
    .port0(port0), .port1(port1), .port2(port2), .port3(port3),
    .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop), .out_eop(out_eop),
    .out_port(out_port), .out_stall(out_stall), .parity_err(parity_err), .pkt_cnt(pkt_cnt)
  );

  always #5 slow_clk = ~slow_clk;

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge slow_clk) cyc <= cyc + 1;

  // Port-side byte queues (driven back) and scoreboard-side packet copies.
  logic [7:0] bq [4][$];
  logic [7:0] mq [4][$];
  int         mlen [4][$];
  logic [7:0] pl [256];
  logic [3:0] ready_v = '0;
  logic [3:0] pend = '0;
  logic [7:0] pv [4];

  // Scoreboard state.
  logic       busy = 1'b0, bad_m = 1'b0, due = 1'b0;
  int         rr_m = 0, g = 0, tlen = 0, k = 0, nreads = 0, gcyc = 0, elig = 0;
  int         due_cyc = 0, itot = 0, atot = 0, pkts_done = 0, last_reads = 0;
  int         first_rd = -1, last_rd = 0, perr_cnt = 0, mp = 0;
  logic       found;
  logic [15:0] exp_cnt = '0;
  logic [7:0] cur [258];
  logic [7:0] xr;
  logic [3:0] rv;
  logic [7:0] dlog [$];
  int         dport_log [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic add_pkt(input int p, input int len, input logic [7:0] dest,
                         input int mode, input logic [7:0] val);
    logic [7:0] b [$];
    logic [7:0] x;
    b.push_back(dest);
    b.push_back(8'(len));
    for (int i = 0; i < len; i++) b.push_back(pl[i]);
    x = '0;
    foreach (b[i]) x ^= b[i];
    if (mode == 1) x = val;
    else if (mode == 2) x ^= val;
    b.push_back(x);
    foreach (b[i]) begin
      bq[p].push_back(b[i]);
      mq[p].push_back(b[i]);
    end
    mlen[p].push_back(len + 3);
  endtask

  task automatic wait_done(input int target, input int budget);
    int n = 0;
    while (pkts_done < target && n < budget) begin
      @(negedge slow_clk);
      n++;
    end
    #2;
    chk("delivery_timeout", 32'(pkts_done >= target), 1);
  endtask

  // Port driver: a read seen in cycle t returns its byte throughout cycle t+1.
  always @(negedge slow_clk) begin
    for (int n = 0; n < 4; n++) begin
      if (pend[n] && bq[n].size() > 0) pv[n] = bq[n].pop_front();
      else pv[n] = 8'($urandom);
    end
    port0 = pv[0]; port1 = pv[1]; port2 = pv[2]; port3 = pv[3];
    ready_v = {bq[3].size() != 0, bq[2].size() != 0, bq[1].size() != 0, bq[0].size() != 0};
    {ready_3, ready_2, ready_1, ready_0} = ready_v;
  end

  // Compare process: evaluates each cycle's outputs against the scoreboard.
  always @(negedge slow_clk) begin
    #1;
    if (!reset_b) begin
      busy = 1'b0; rr_m = 0; exp_cnt = '0; due = 1'b0; elig = 0;
      itot = 0; atot = 0; pend = '0;
    end else begin
      if (due && cyc >= due_cyc) begin
        exp_cnt = exp_cnt + 16'd1;
        due = 1'b0;
      end
      chk("pkt_cnt", 32'(pkt_cnt), 32'(exp_cnt));
      if (!busy && cyc >= elig && ready_v != 4'b0) begin
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
          mp = (rr_m + i) % 4;
          if (!found && ready_v[mp]) begin
            g = mp;
            found = 1'b1;
          end
        end
        tlen = mlen[g].pop_front();
        xr = '0;
        for (int j = 0; j < tlen; j++) begin
          cur[j] = mq[g].pop_front();
          if (j < tlen - 1) xr ^= cur[j];
        end
        bad_m = (xr != cur[tlen-1]);
        busy = 1'b1; k = 0; nreads = 0; gcyc = cyc; first_rd = -1;
      end
      rv = {read_3, read_2, read_1, read_0};
      if (rv != 4'b0) begin
        chk("read_owner", 32'(rv), (busy && cyc > gcyc) ? (32'd1 << g) : 32'd0);
        nreads++; itot++;
        if (first_rd < 0) first_rd = cyc;
        last_rd = cyc;
      end
      pend = rv;
      if (out_valid) begin
        if (!busy || k >= tlen) chk("spurious_valid", 1, 0);
        else begin
          chk("out_data", 32'(out_data), 32'(cur[k]));
          chk("out_sop", 32'(out_sop), 32'(k == 0));
          chk("out_eop", 32'(out_eop), 32'(k == tlen - 1));
          chk("out_port", 32'(out_port), 32'(g));
          if (!out_stall) begin
            atot++;
            dlog.push_back(out_data);
            if (k == 0) dport_log.push_back(int'(out_port));
            chk("parity_err", 32'(parity_err), 32'((k == tlen - 1) && bad_m));
            if (parity_err) perr_cnt++;
            if (k == tlen - 1) begin
              chk("reads_per_pkt", 32'(nreads), 32'(tlen));
              last_reads = nreads;
              busy = 1'b0; elig = cyc + 2; rr_m = (g + 1) % 4;
              due = 1'b1; due_cyc = cyc + 2; pkts_done++;
            end
            k++;
          end else chk("parity_err_stalled", 32'(parity_err), 0);
        end
      end else chk("parity_err_idle", 32'(parity_err), 0);
      chk("inflight_bound", 32'((itot - atot) <= 2), 1);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [7:0] e1 [5];
  logic [7:0] e3 [7];
  int e2 [5];
  int base, n, isnap, pbase, added, len;

  initial begin
    e1 = '{8'h22, 8'h02, 8'hAA, 8'h55, 8'hDF};
    e2 = '{0, 1, 2, 3, 0};
    e3 = '{8'h11, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h11};
    repeat (3) @(negedge slow_clk);
    #2;
    chk("rst_reads", 32'({read_3, read_2, read_1, read_0}), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_sop_eop", 32'({out_sop, out_eop}), 0);
    chk("rst_port", 32'(out_port), 0);
    chk("rst_perr", 32'(parity_err), 0);
    chk("rst_pkt_cnt", 32'(pkt_cnt), 0);
    @(negedge slow_clk);
    reset_b = 1'b1;

    // Single good packet from port 2; parity byte 0xDF is the XOR of the first four.
    dlog.delete(); dport_log.delete();
    pl[0] = 8'hAA; pl[1] = 8'h55;
    add_pkt(2, 2, 8'h22, 0, 8'h00);
    wait_done(1, 200);
    chk("t1_len", 32'(dlog.size()), 5);
    for (int i = 0; i < 5 && i < dlog.size(); i++) chk("t1_byte", 32'(dlog[i]), 32'(e1[i]));
    chk("t1_port", 32'((dport_log.size() > 0) ? dport_log[0] : -1), 2);
    chk("t1_reads", 32'(last_reads), 5);
    chk("t1_read_span", 32'(last_rd - first_rd + 1), 5);
    chk("t1_first_read", 32'(first_rd - gcyc), 1);
    repeat (3) @(negedge slow_clk);
    #2;
    chk("t1_pkt_cnt", 32'(pkt_cnt), 1);
    chk("t1_perr", 32'(perr_cnt), 0);

    // Bad parity from port 3: running XOR is 0x8F, parity byte 0x00.
    pl[0] = 8'hBE;
    add_pkt(3, 1, 8'h30, 1, 8'h00);
    wait_done(2, 200);
    repeat (3) @(negedge slow_clk);
    #2;
    chk("t2_perr_pulses", 32'(perr_cnt), 1);
    chk("t2_pkt_cnt", 32'(pkt_cnt), 2);

    // All four ports continuously ready with L=0 packets.
    @(negedge slow_clk);
    dport_log.delete();
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < 4; p++) add_pkt(p, 0, 8'(8'h40 + p), 0, 8'h00);
    wait_done(10, 400);
    for (int i = 0; i < 5 && i < dport_log.size(); i++) chk("t3_grant", 32'(dport_log[i]), 32'(e2[i]));
    chk("t3_reads", 32'(last_reads), 3);
    repeat (3) @(negedge slow_clk);
    #2;
    chk("t3_pkt_cnt", 32'(pkt_cnt), 10);

    // Port 1, L=4, stall from the second output byte for ten cycles.
    @(negedge slow_clk);
    dlog.delete();
    for (int i = 0; i < 4; i++) pl[i] = 8'(i + 1);
    add_pkt(1, 4, 8'h11, 0, 8'h00);
    n = 0;
    while (dlog.size() < 1 && n < 100) begin
      @(negedge slow_clk);
      n++;
    end
    out_stall = 1'b1;
    repeat (2) @(negedge slow_clk);
    #2 isnap = itot;
    repeat (7) @(negedge slow_clk);
    #2;
    chk("t4_reads_stalled", 32'(itot - isnap), 0);
    chk("t4_buffered", 32'(itot - atot), 2);
    chk("t4_accepted", 32'(dlog.size()), 1);
    @(negedge slow_clk);
    out_stall = 1'b0;
    wait_done(11, 200);
    chk("t4_len", 32'(dlog.size()), 7);
    for (int i = 0; i < 7 && i < dlog.size(); i++) chk("t4_byte", 32'(dlog[i]), 32'(e3[i]));

    // Maximum length packet.
    @(negedge slow_clk);
    dlog.delete();
    for (int i = 0; i < 255; i++) pl[i] = 8'($urandom);
    add_pkt(0, 255, 8'h0F, 0, 8'h00);
    wait_done(12, 1000);
    chk("t5_reads", 32'(last_reads), 258);
    chk("t5_len", 32'(dlog.size()), 258);

    // Random traffic with random backpressure and occasional parity faults.
    base = pkts_done; added = 0;
    while (added < 40) begin
      @(negedge slow_clk);
      out_stall = ($urandom_range(3) == 0);
      if ($urandom_range(7) == 0) begin
        len = $urandom_range(20);
        for (int i = 0; i < len; i++) pl[i] = 8'($urandom);
        add_pkt($urandom_range(3), len, 8'($urandom), ($urandom_range(9) == 0) ? 2 : 0, 8'h01);
        added++;
      end
    end
    @(negedge slow_clk);
    out_stall = 1'b0;
    wait_done(base + 40, 6000);

    // Asynchronous reset in the middle of a transfer.
    @(negedge slow_clk);
    dlog.delete();
    for (int i = 0; i < 10; i++) pl[i] = 8'($urandom);
    add_pkt(2, 10, 8'h77, 0, 8'h00);
    n = 0;
    while (dlog.size() < 3 && n < 100) begin
      @(negedge slow_clk);
      n++;
    end
    @(posedge slow_clk);
    #3 reset_b = 1'b0;
    #1;
    chk("ar_reads", 32'({read_3, read_2, read_1, read_0}), 0);
    chk("ar_valid", 32'(out_valid), 0);
    chk("ar_sop_eop", 32'({out_sop, out_eop}), 0);
    chk("ar_port", 32'(out_port), 0);
    chk("ar_perr", 32'(parity_err), 0);
    chk("ar_pkt_cnt", 32'(pkt_cnt), 0);
    for (int p = 0; p < 4; p++) begin
      bq[p].delete(); mq[p].delete(); mlen[p].delete();
    end
    repeat (2) @(negedge slow_clk);
    dport_log.delete();
    pbase = pkts_done;
    pl[0] = 8'h5A; pl[1] = 8'hC3;
    add_pkt(3, 2, 8'h33, 0, 8'h00);
    add_pkt(1, 2, 8'h31, 0, 8'h00);
    repeat (2) @(negedge slow_clk);
    reset_b = 1'b1;
    wait_done(pbase + 2, 200);
    chk("ar_first_grant", 32'((dport_log.size() > 0) ? dport_log[0] : -1), 1);
    chk("ar_second_grant", 32'((dport_log.size() > 1) ? dport_log[1] : -1), 3);
    repeat (3) @(negedge slow_clk);
    #2;
    chk("ar_pkt_cnt_after", 32'(pkt_cnt), 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
